// File: rtl/button_cursor_ctrl.sv
// button_cursor_ctrl: sync/debounce move+select buttons, own board cursor, hand selections to game core
//   clk, rst (async active-low) ; move_n, select_n raw active-low buttons ; en gates presses
//   sel_valid/sel_cell/sel_ready selection handshake ; cursor, cursor_onehot, move_pulse cursor view
module button_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_CELLS = 16,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_n,
  input  logic                 select_n,
  input  logic                 en,
  input  logic                 sel_ready,
  output logic                 sel_valid,
  output logic [CW-1:0]        sel_cell,
  output logic [CW-1:0]        cursor,
  output logic [NUM_CELLS-1:0] cursor_onehot,
  output logic                 move_pulse
);
  localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CUR_LAST = CW'(NUM_CELLS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  // bit 0 = move, bit 1 = select
  logic [1:0] s1_q, s2_q, st_q, st_d, prev_q, press;
  logic [NW-1:0] cnt_q [2];
  logic [NW-1:0] cnt_d [2];
  logic [CW-1:0] cursor_q, cursor_d, sel_cell_q, sel_cell_d;
  logic [NUM_CELLS-1:0] onehot_q, onehot_d;
  logic [0:0] state_q, state_d;
  logic move_pulse_q, move_pulse_d;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == st_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_LAST) begin
        st_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
    // press is the single cycle after the debounced level falls
    press = prev_q & ~st_q;
    move_pulse_d = press[0] && en;
    cursor_d = move_pulse_d ? ((cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1) : cursor_q;
    onehot_d = NUM_CELLS'(1) << cursor_d;
    state_d = (state_q == IDLE) ? ((press[1] && en) ? PEND : IDLE) : (sel_ready ? IDLE : PEND);
    // capture the pre-move cursor so a simultaneous move does not leak into the selection
    sel_cell_d = (state_q == IDLE && press[1] && en) ? cursor_q : sel_cell_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      st_q <= 2'b11;
      prev_q <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      cursor_q <= '0;
      onehot_q <= NUM_CELLS'(1);
      state_q <= IDLE;
      sel_cell_q <= '0;
      move_pulse_q <= 1'b0;
    end else begin
      s1_q <= {select_n, move_n};
      s2_q <= s1_q;
      st_q <= st_d;
      prev_q <= st_q;
      cnt_q <= cnt_d;
      cursor_q <= cursor_d;
      onehot_q <= onehot_d;
      state_q <= state_d;
      sel_cell_q <= sel_cell_d;
      move_pulse_q <= move_pulse_d;
    end
  end
  assign sel_valid = (state_q == PEND);
  assign sel_cell = sel_cell_q;
  assign cursor = cursor_q;
  assign cursor_onehot = onehot_q;
  assign move_pulse = move_pulse_q;
endmodule
